// File: rtl/program_loader_if.sv
// Host byte stream and instruction RAM write port of the program loader.
//
// Stream handshake: a byte in in_data moves only on a rising clk edge where
// in_valid and in_ready are both 1. The producer may raise or drop in_valid
// at any time between bytes. in_ready never looks at in_valid.
//
// RAM write port: mem_we is a one-cycle strobe; mem_addr/mem_wdata are valid
// whenever mem_we is 1.
interface program_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;

    // Host / environment side: drives the stream, observes the RAM port.
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    // Loader side: consumes the stream, drives the RAM port.
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/program_loader.sv
// Loads a framed program image ({MAGIC, N-1}, N data bytes, 8-bit sum) into
// the 16 x 8 instruction RAM while holding the processor in reset. The hold
// is released only after a frame whose checksum matches.
module program_loader #(
    parameter logic [3:0] MAGIC = 4'hA
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_req,
    input  logic             abort,
    program_loader_if.slave  bus,
    output logic             cpu_hold,
    output logic             done,
    output logic             err,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_DATA   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [4:0] cnt;        // next write address; stops at 16
    logic [3:0] last_idx;   // N-1 from the header
    logic [7:0] sum;        // running sum of data bytes, wraps mod 256

    logic       mem_we_q;
    logic [3:0] mem_addr_q;
    logic [7:0] mem_wdata_q;

    logic       active;
    logic       in_ready;
    logic       accept;
    logic       start;
    logic       hdr_ok;
    logic       last_data;
    logic       sum_ok;
    logic       wr_data;
    logic       set_err;

    // Handshake and frame-field decode shared by the FSM and the datapath.
    always_comb begin
        active    = (state == ST_HEADER) || (state == ST_DATA) || (state == ST_CHECK);
        in_ready  = active && !abort;
        accept    = in_ready && bus.in_valid;
        start     = (state == ST_IDLE) && load_req;
        hdr_ok    = (bus.in_data[7:4] == MAGIC);
        last_data = (cnt == {1'b0, last_idx});
        sum_ok    = (bus.in_data == sum);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle control strobes.
    always_comb begin
        state_next = state;
        wr_data    = 1'b0;
        set_err    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (load_req) state_next = ST_HEADER;
            end
            ST_HEADER: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    set_err    = 1'b1;
                end else if (accept) begin
                    if (hdr_ok) begin
                        state_next = ST_DATA;
                    end else begin
                        state_next = ST_IDLE;
                        set_err    = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    set_err    = 1'b1;
                end else if (accept) begin
                    wr_data = 1'b1;
                    if (last_data) state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    set_err    = 1'b1;
                end else if (accept) begin
                    if (sum_ok) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_IDLE;
                        set_err    = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Header length capture: only a header with the right magic updates N-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_idx <= 4'd0;
        end else if (state == ST_HEADER && accept && hdr_ok) begin
            last_idx <= bus.in_data[3:0];
        end
    end

    // Address counter: cleared at session start, saturates at 16.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 5'd0;
        end else if (start) begin
            cnt <= 5'd0;
        end else if (wr_data && cnt != 5'd16) begin
            cnt <= cnt + 5'd1;
        end
    end

    // Checksum accumulator over data bytes only.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= 8'd0;
        end else if (start) begin
            sum <= 8'd0;
        end else if (wr_data) begin
            sum <= sum + bus.in_data;
        end
    end

    // Registered RAM write port; address/data hold their last value between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 4'd0;
            mem_wdata_q <= 8'd0;
        end else begin
            mem_we_q <= wr_data;
            if (wr_data) begin
                mem_addr_q  <= cnt[3:0];
                mem_wdata_q <= bus.in_data;
            end
        end
    end

    // Processor hold: raised at session start, dropped only when leaving DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_hold <= 1'b0;
        end else if (start) begin
            cpu_hold <= 1'b1;
        end else if (state == ST_DONE) begin
            cpu_hold <= 1'b0;
        end
    end

    // Sticky error: cleared only by a new session or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (start) begin
            err <= 1'b0;
        end else if (set_err) begin
            err <= 1'b1;
        end
    end

    assign done          = (state == ST_DONE);
    assign state_dbg     = state;
    assign bus.in_ready  = in_ready;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a frame-level expectation model.
module tb_program_loader;
    localparam logic [3:0] MAGIC = 4'hA;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_req;
    logic       abort;
    logic       cpu_hold;
    logic       done;
    logic       err;
    logic [2:0] state_dbg;

    program_loader_if bus();

    program_loader #(.MAGIC(MAGIC)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_req  (load_req),
        .abort     (abort),
        .bus       (bus),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    int checks   = 0;
    int failures = 0;

    // Scoreboard: expected RAM writes {addr, data} and expected done pulses.
    logic [11:0] exp_q[$];
    int          exp_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Compare process: every write and every done pulse must be expected.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_write: got addr=%0h data=%0h want no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                check("write", {20'd0, bus.mem_addr, bus.mem_wdata}, {20'd0, exp_q.pop_front()});
            end
        end
        if (done === 1'b1) begin
            checks++;
            if (exp_done == 0) begin
                failures++;
                $display("FAIL spurious_done: got done=1 want done=0");
            end else begin
                exp_done--;
            end
        end
    end

    // Model: plain 8-bit sum of the data bytes.
    function automatic logic [7:0] model_sum(input logic [7:0] d[$]);
        int s = 0;
        foreach (d[i]) s += int'(d[i]);
        return 8'(s % 256);
    endfunction

    // Model: a frame with a good header writes its bytes at 0..N-1; it
    // completes only if the checksum matches.
    task automatic model_frame(input logic [7:0] hdr, input logic [7:0] d[$],
                               input logic [7:0] ck, output bit ok);
        ok = 1'b0;
        if (hdr[7:4] == MAGIC) begin
            for (int i = 0; i < int'(hdr[3:0]) + 1; i++) exp_q.push_back({4'(i), d[i]});
            ok = (ck == model_sum(d));
            if (ok) exp_done++;
        end
    endtask

    // Driver tasks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok = 1'b0;
        int waited = 0;
        if (gaps) begin
            int idle = $urandom_range(0, 2);
            for (int k = 0; k < idle; k++) tick();
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!ok && waited < 20) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) ok = 1'b1;
            tick();
            waited++;
        end
        bus.in_valid = 1'b0;
        check("byte_accepted", {31'd0, ok}, 32'd1);
    endtask

    task automatic start_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        check("hold_rise", {31'd0, cpu_hold}, 32'd1);
        check("err_cleared", {31'd0, err}, 32'd0);
    endtask

    task automatic load_frame(input logic [7:0] hdr, input logic [7:0] d[$],
                              input logic [7:0] ck, input bit gaps, input bit pulse_req);
        bit ok;
        start_load();
        model_frame(hdr, d, ck, ok);
        send_byte(hdr, gaps);
        if (hdr[7:4] != MAGIC) begin
            check("hdr_err", {31'd0, err}, 32'd1);
            check("hdr_hold", {31'd0, cpu_hold}, 32'd1);
            tick();
            check("hdr_no_writes", exp_q.size(), 32'd0);
            return;
        end
        for (int i = 0; i < d.size(); i++) begin
            send_byte(d[i], gaps);
            if (pulse_req && i == 1) begin
                load_req = 1'b1;
                tick();
                load_req = 1'b0;
            end
        end
        send_byte(ck, gaps);
        if (ok) begin
            check("done_pulse", {31'd0, done}, 32'd1);
            tick();
            check("done_once", {31'd0, done}, 32'd0);
            check("hold_released", {31'd0, cpu_hold}, 32'd0);
            check("err_clean", {31'd0, err}, 32'd0);
        end else begin
            check("ck_err", {31'd0, err}, 32'd1);
            check("ck_hold", {31'd0, cpu_hold}, 32'd1);
            tick();
            check("ck_no_done", {31'd0, done}, 32'd0);
        end
        check("writes_drained", exp_q.size(), 32'd0);
        check("done_count", exp_done, 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        check({tag, "_mem_we"}, {31'd0, bus.mem_we}, 32'd0);
        check({tag, "_mem_addr"}, {28'd0, bus.mem_addr}, 32'd0);
        check({tag, "_mem_wdata"}, {24'd0, bus.mem_wdata}, 32'd0);
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_idle_state"}, {29'd0, state_dbg}, 32'd0);
    endtask

    // Offer a byte for a few cycles while idle; none may be accepted.
    task automatic offer_idle(input logic [7:0] b, input string tag);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check(tag, {31'd0, bus.in_ready}, 32'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        check({tag, "_no_writes"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [7:0] clean[$];
        logic [7:0] full[$];
        clean = '{8'h1B, 8'h2C, 8'h3D, 8'h4E};
        for (int i = 0; i < 16; i++) full.push_back(8'(i));

        rst          = 1'b1;
        load_req     = 1'b0;
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        // Pin the model against hand-computed checksums.
        check("model_sum_clean", {24'd0, model_sum(clean)}, 32'hD2);
        check("model_sum_full", {24'd0, model_sum(full)}, 32'h78);

        // Clean load, back-to-back bytes.
        load_frame(8'hA3, clean, 8'hD2, 1'b0, 1'b0);

        // Bad checksum, then a clean load recovers.
        load_frame(8'hA3, clean, 8'hD3, 1'b0, 1'b0);
        load_frame(8'hA3, clean, 8'hD2, 1'b0, 1'b0);

        // Bad header; a following byte is refused.
        load_frame(8'h53, clean, 8'hD2, 1'b0, 1'b0);
        offer_idle(8'h1B, "after_bad_hdr_ready");
        check("bad_hdr_err_sticky", {31'd0, err}, 32'd1);

        // Full 16-byte image.
        load_frame(8'hAF, full, 8'h78, 1'b0, 1'b0);

        // Random gaps with a stray load_req mid-DATA.
        load_frame(8'hA3, clean, 8'hD2, 1'b1, 1'b1);

        // Abort mid-DATA after two writes.
        start_load();
        send_byte(8'hA3, 1'b0);
        exp_q.push_back({4'd0, 8'h1B});
        send_byte(8'h1B, 1'b0);
        exp_q.push_back({4'd1, 8'h2C});
        send_byte(8'h2C, 1'b0);
        bus.in_data  = 8'h3D;
        bus.in_valid = 1'b1;
        abort        = 1'b1;
        @(negedge clk);
        check("abort_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        check("abort_err", {31'd0, err}, 32'd1);
        check("abort_hold", {31'd0, cpu_hold}, 32'd1);
        offer_idle(8'h3D, "after_abort_ready");

        // Reset during DATA after two writes.
        start_load();
        send_byte(8'hA3, 1'b0);
        exp_q.push_back({4'd0, 8'h1B});
        send_byte(8'h1B, 1'b0);
        exp_q.push_back({4'd1, 8'h2C});
        send_byte(8'h2C, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("midrst");
        offer_idle(8'h3D, "after_rst_ready");

        // Recovery after reset.
        load_frame(8'hA3, clean, 8'hD2, 1'b0, 1'b0);

        repeat (3) tick();
        check("final_writes_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Writes a new program image into the processor's 16 x 8 instruction memory from an external byte stream. The loader holds the processor in reset for the whole load, checks a header and an 8-bit checksum, and releases the processor only after a clean load, so execution restarts at address 0. It sits between the host-facing input pins and the write port of the instruction RAM, beside the `processor` core.

## Interface
- `MAGIC` — default `4'hA` — required upper nibble of the header byte.
- `clk` — input, 1 — the single clock; all state changes on its rising edge.
- `rst` — input, 1 — synchronous, active-high reset.
- `load_req` — input, 1 — starts a load session; sampled only in IDLE.
- `abort` — input, 1 — cancels an active session.
- `in_data` — input, 8 — stream byte.
- `in_valid` — input, 1 — `in_data` is valid.
- `in_ready` — output, 1 — loader accepts a byte this cycle.
- `mem_we` — output, 1 — instruction RAM write enable, one-cycle pulse per byte.
- `mem_addr` — output, 4 — instruction RAM write address.
- `mem_wdata` — output, 8 — instruction RAM write data.
- `cpu_hold` — output, 1 — drives the processor's `rst` input.
- `done` — output, 1 — one-cycle pulse when a load completes cleanly.
- `err` — output, 1 — sticky error flag.

## Operation
- Byte transfer: a byte moves only in a cycle where `in_valid` and `in_ready` are both 1. `in_valid` may drop between bytes at any time.
- Frame format:
  - Header byte: `{MAGIC, N-1}`, so N = 1..16 data bytes.
  - Then N data bytes.
  - Then a checksum byte equal to the sum of the data bytes mod 256. The header is not included in the sum.
- States: IDLE, HEADER, DATA, CHECK, DONE.
- IDLE:
  - `in_ready` = 0.
  - `load_req` = 1 moves to HEADER. In the same edge: `cpu_hold` <- 1, `err` <- 0, byte counter <- 0, sum <- 0.
- HEADER: `in_ready` = 1. On an accepted byte:
  - If the upper nibble equals `MAGIC`: store N-1 and go to DATA.
  - Otherwise: `err` <- 1 and go to IDLE.
- DATA: `in_ready` = 1. On an accepted byte:
  - Register `mem_addr` <- counter, `mem_wdata` <- byte, `mem_we` <- 1.
  - sum <- sum + byte (8-bit, wraps).
  - counter increments.
  - After byte N, go to CHECK.
- CHECK: `in_ready` = 1. On an accepted byte:
  - If the byte equals sum: go to DONE.
  - Otherwise: `err` <- 1 and go to IDLE.
- DONE: `done` = 1 and `cpu_hold` <- 0 on leaving DONE. Always returns to IDLE after one cycle.
- `cpu_hold` after any error stays 1 until a later load succeeds. The processor never runs a partially written or corrupt image.
- `abort` in HEADER, DATA or CHECK: go to IDLE, `err` <- 1, `cpu_hold` stays 1. Any byte offered in that cycle is not accepted (`in_ready` is forced to 0). `abort` in IDLE or DONE is ignored.
- `load_req` outside IDLE is ignored.
- Address range: addresses always start at 0 and run 0..N-1. The counter is 5 bits internally and never wraps past 15.
- Bytes after a completed frame are not accepted (`in_ready` = 0 in IDLE).

## Timing
- Reset values: state IDLE, `in_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `cpu_hold` 0, `done` 0, `err` 0, counter 0, sum 0. The processor runs its resident image after reset.
- `rst` mid-session wins over all inputs and restores the reset values, including `cpu_hold` = 0.
- `in_ready` is a combinational function of state and `abort` only; it never depends on `in_valid`.
- Write latency: `mem_we`, `mem_addr` and `mem_wdata` are registered and appear the cycle after the byte is accepted. `mem_we` is high for exactly one cycle per data byte.
- Back-to-back bytes are accepted every cycle, which gives at most one write per cycle.
- `cpu_hold` rises the cycle after `load_req` is sampled.
- The checksum byte is accepted at edge T. The state is DONE in cycle T+1, so `done` = 1 during T+1. `cpu_hold` is 0 from T+2.
- The last `mem_we` occurs no later than the cycle in which the checksum is accepted.
- Minimum session length: N+2 accepted bytes, plus the IDLE->HEADER cycle and the DONE cycle.

## Test plan
- **Clean load:** `load_req`, then stream 0xA3, 0x1B, 0x2C, 0x3D, 0x4E, 0xD2 back-to-back.
  - Expect writes (0,0x1B), (1,0x2C), (2,0x3D), (3,0x4E).
  - Expect one `done` pulse, `cpu_hold` 1->0, `err` 0.
- **Bad checksum:** same frame with checksum 0xD3.
  - Expect the four writes, then `err` = 1, no `done`, `cpu_hold` held at 1.
  - A following clean load clears `err` and releases `cpu_hold`.
- **Bad header:** header 0x53.
  - Expect `err` = 1, no `mem_we`, return to IDLE.
  - A following data byte sees `in_ready` = 0.
- **Full image:** header 0xAF, data 0x00..0x0F, checksum 0x78.
  - Expect 16 writes at addresses 0..15 with no wrap, then `done`.
- **Gaps and protocol errors:** clean frame with `in_valid` toggled randomly.
  - Expect identical writes and `done`.
  - `load_req` pulsed mid-DATA is ignored.
  - `abort` mid-DATA gives `err` = 1, no further writes, `cpu_hold` = 1.
- **Reset mid-load:** `rst` during DATA after 2 writes.
  - Expect all outputs at reset values the next cycle, `cpu_hold` = 0.
  - Subsequent bytes are not accepted until a new `load_req`.
